// File: rtl/phase_pkg.sv
// Shared definitions for the phase_rx dual-rail receiver: rail codes,
// channel FSM states and phase index constants.
package phase_pkg;

  localparam logic [1:0] DR_SPACER  = 2'b00;
  localparam logic [1:0] DR_ONE     = 2'b10;
  localparam logic [1:0] DR_ZERO    = 2'b01;
  localparam logic [1:0] DR_ILLEGAL = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } chan_state_t;

  localparam int unsigned N_PH    = 3;
  localparam int unsigned PH_IDX0 = 0;
  localparam int unsigned PH_IDX1 = 1;
  localparam int unsigned PH_IDX2 = 2;

  // Expected-phase pointer encodings.
  localparam logic [1:0] PH_0 = 2'd0;
  localparam logic [1:0] PH_1 = 2'd1;
  localparam logic [1:0] PH_2 = 2'd2;

endpackage

// File: rtl/phase_rx_chan.sv
// One dual-rail phase channel: input synchronizer plus IDLE/HOLD 4-phase
// acknowledge FSM.
//   state   | meaning
//   ST_IDLE | ack low, waiting for a data code
//   ST_HOLD | ack high, token latched, waiting for spacer
module phase_rx_chan
  import phase_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] rail,
  output logic       ack,
  output logic       valid,
  output logic       bit_val,
  output logic       proto_err
);

  logic [SYNC_STAGES-1:0][1:0] sync_q;
  logic [1:0]                  code;
  chan_state_t                 state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rail};
    end
  end

  assign code = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ack       <= 1'b0;
      valid     <= 1'b0;
      bit_val   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      proto_err <= 1'b0;
      if (code == DR_ILLEGAL) begin
        proto_err <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (code != DR_SPACER) begin
              state   <= ST_HOLD;
              ack     <= 1'b1;
              valid   <= 1'b1;
              bit_val <= (code == DR_ONE);
            end
          end
          ST_HOLD: begin
            if (code == DR_SPACER) begin
              state <= ST_IDLE;
              ack   <= 1'b0;
            end else if ((code == DR_ONE) != bit_val) begin
              // Data flipped polarity without passing through a spacer.
              proto_err <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/phase_rx.sv
// Three-channel dual-rail phase receiver with sequence counter and sticky
// error flag. Define PHASE_RX_ORDER_CHECK_EN to enforce PH0->PH1->PH2 order.
module phase_rx
  import phase_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       PH0,
  input  logic [1:0]       PH1,
  input  logic [1:0]       PH2,
  output logic             ackPH0,
  output logic             ackPH1,
  output logic             ackPH2,
  output logic [2:0]       ph_valid,
  output logic [2:0]       ph_bit,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             err
);

  logic [1:0] rst_pipe;
  logic       rst_int_n;
  logic [2:0] proto_err;
  logic       order_err;
  logic       cnt_inc;

  // Assert immediately, release two clocks after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_pipe <= 2'b00;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b1};
    end
  end

  assign rst_int_n = rst_pipe[1];

  phase_rx_chan #(.SYNC_STAGES(SYNC_STAGES)) u_chan0 (
    .clk(clk), .rst_n(rst_int_n), .rail(PH0), .ack(ackPH0),
    .valid(ph_valid[PH_IDX0]), .bit_val(ph_bit[PH_IDX0]), .proto_err(proto_err[PH_IDX0])
  );

  phase_rx_chan #(.SYNC_STAGES(SYNC_STAGES)) u_chan1 (
    .clk(clk), .rst_n(rst_int_n), .rail(PH1), .ack(ackPH1),
    .valid(ph_valid[PH_IDX1]), .bit_val(ph_bit[PH_IDX1]), .proto_err(proto_err[PH_IDX1])
  );

  phase_rx_chan #(.SYNC_STAGES(SYNC_STAGES)) u_chan2 (
    .clk(clk), .rst_n(rst_int_n), .rail(PH2), .ack(ackPH2),
    .valid(ph_valid[PH_IDX2]), .bit_val(ph_bit[PH_IDX2]), .proto_err(proto_err[PH_IDX2])
  );

`ifdef PHASE_RX_ORDER_CHECK_EN
  logic [1:0] exp_ptr;
  logic [2:0] exp_onehot;
  logic       in_order;

  assign exp_onehot = 3'b001 << exp_ptr;
  // A lone acceptance on the expected channel; multiples never match.
  assign in_order   = (ph_valid == exp_onehot);
  assign order_err  = (|ph_valid) && !in_order;
  assign cnt_inc    = in_order && (exp_ptr == PH_2);

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      exp_ptr <= PH_0;
    end else if (in_order) begin
      exp_ptr <= (exp_ptr == PH_2) ? PH_0 : exp_ptr + 2'd1;
    end
  end
`else
  assign order_err = 1'b0;
  assign cnt_inc   = ph_valid[PH_IDX2];
`endif

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      cycle_cnt <= '0;
      err       <= 1'b0;
    end else begin
      if (cnt_inc) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      end
      if ((|proto_err) || order_err) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_phase_rx.sv
// Self-checking bench for phase_rx: vector table, randomized handshakes
// against a transaction-level model, and directed corner sequences.
module tb_phase_rx;

  localparam int S  = 2;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    rails [3];
  logic          ackPH0, ackPH1, ackPH2;
  logic [2:0]    ph_valid, ph_bit;
  logic [CW-1:0] cycle_cnt;
  logic          err;
  logic [2:0]    acks;

  int total = 0;
  int bad   = 0;

  logic [2:0] m_bit;
  int         m_cnt;

  typedef struct {
    int         ch;
    logic [1:0] code;
    logic [2:0] exp_bit;
    int         exp_cnt;
  } vec_t;

  vec_t tbl [9];

  phase_rx #(.SYNC_STAGES(S), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .PH0(rails[0]), .PH1(rails[1]), .PH2(rails[2]),
    .ackPH0(ackPH0), .ackPH1(ackPH1), .ackPH2(ackPH2),
    .ph_valid(ph_valid), .ph_bit(ph_bit), .cycle_cnt(cycle_cnt), .err(err)
  );

  assign acks = {ackPH2, ackPH1, ackPH0};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) rails[i] = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_acks", {29'd0, acks}, 0);
    check("rst_valid_bit", {26'd0, ph_valid, ph_bit}, 0);
    check("rst_cnt_err", {23'd0, err, cycle_cnt}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    m_bit = 3'b000;
    m_cnt = 0;
  endtask

  // Waits for acks[ch] to reach lvl; returns edges taken (S+7 on timeout).
  task automatic wait_ack(input int ch, input logic lvl, inout int vc, output int k);
    for (k = 1; k <= S + 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (ph_valid[ch]) vc++;
      if (acks[ch] == lvl) break;
    end
  endtask

  // Full 4-phase handshake on one channel, checked against the model.
  task automatic send(input int ch, input logic [1:0] code);
    int k;
    int vc = 0;
    rails[ch] = code;
    wait_ack(ch, 1'b1, vc, k);
    check("ack_rise_lat", k, S + 1);
    m_bit[ch] = (code == 2'b10);
    check("ph_bit", {29'd0, ph_bit}, {29'd0, m_bit});
    rails[ch] = 2'b00;
    wait_ack(ch, 1'b0, vc, k);
    check("ack_fall_lat", k, S + 1);
    check("valid_pulses", vc, 1);
    if (ch == 2) m_cnt = (m_cnt + 1) % (1 << CW);
    check("cycle_cnt", {24'd0, cycle_cnt}, m_cnt);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, vc, nxt, ahi;
    logic [1:0] code;

    tbl[0] = '{0, 2'b10, 3'b001, 0};
    tbl[1] = '{1, 2'b01, 3'b001, 0};
    tbl[2] = '{2, 2'b10, 3'b101, 1};
    tbl[3] = '{0, 2'b01, 3'b100, 1};
    tbl[4] = '{1, 2'b10, 3'b110, 1};
    tbl[5] = '{2, 2'b01, 3'b010, 2};
    tbl[6] = '{0, 2'b10, 3'b011, 2};
    tbl[7] = '{1, 2'b10, 3'b011, 2};
    tbl[8] = '{2, 2'b10, 3'b111, 3};

    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) rails[i] = 2'b00;
    do_reset();

    for (int i = 0; i < 9; i++) begin
      send(tbl[i].ch, tbl[i].code);
      check("tbl_bit", {29'd0, ph_bit}, {29'd0, tbl[i].exp_bit});
      check("tbl_cnt", {24'd0, cycle_cnt}, tbl[i].exp_cnt);
    end
    check("tbl_err", {31'd0, err}, 0);

    nxt = 0;
    for (int i = 0; i < 40; i++) begin
`ifdef PHASE_RX_ORDER_CHECK_EN
      k   = nxt;
      nxt = (nxt + 1) % 3;
`else
      k = $urandom_range(0, 2);
`endif
      code = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(k, code);
    end
    check("rand_err", {31'd0, err}, 0);

    // Out-of-order first token on PH1.
    do_reset();
    vc = 0;
    rails[1] = 2'b10;
    wait_ack(1, 1'b1, vc, k);
    check("ooo_ack_lat", k, S + 1);
    rails[1] = 2'b00;
    wait_ack(1, 1'b0, vc, k);
    repeat (2) @(negedge clk);
`ifdef PHASE_RX_ORDER_CHECK_EN
    check("ooo_err", {31'd0, err}, 1);
`else
    check("ooo_err", {31'd0, err}, 0);
`endif

    // Illegal 11 on PH1.
    do_reset();
    vc = 0;
    ahi = 0;
    rails[1] = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ph_valid[1]) vc++;
      if (ackPH1) ahi++;
    end
    rails[1] = 2'b00;
    for (int i = 0; i < S + 3; i++) begin
      @(negedge clk);
      if (ph_valid[1]) vc++;
      if (ackPH1) ahi++;
    end
    check("ill_err", {31'd0, err}, 1);
    check("ill_ack", ahi, 0);
    check("ill_valid", vc, 0);

    // PH2 flips 10->01 while held.
    do_reset();
    send(0, 2'b10);
    send(1, 2'b01);
    vc = 0;
    rails[2] = 2'b10;
    wait_ack(2, 1'b1, vc, k);
    check("flip_rise_lat", k, S + 1);
    vc = 0;
    rails[2] = 2'b01;
    for (int i = 0; i < S + 3; i++) begin
      @(negedge clk);
      if (ph_valid[2]) vc++;
    end
    check("flip_err", {31'd0, err}, 1);
    check("flip_ack", {31'd0, ackPH2}, 1);
    check("flip_valid", vc, 0);
    rails[2] = 2'b00;
    wait_ack(2, 1'b0, vc, k);
    check("flip_fall_lat", k, S + 1);

    // Reset pulse mid-handshake.
    do_reset();
    vc = 0;
    rails[0] = 2'b10;
    wait_ack(0, 1'b1, vc, k);
    rst_n = 1'b0;
    #1;
    check("async_ack0", {31'd0, ackPH0}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    vc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ph_valid[0]) vc++;
    end
    check("reack_valid", vc, 1);
    check("reack_ack0", {31'd0, ackPH0}, 1);
    check("reack_err", {31'd0, err}, 0);
    rails[0] = 2'b00;
    wait_ack(0, 1'b0, vc, k);
    check("reack_fall_lat", k, S + 1);

    // Simultaneous PH0 and PH1 tokens.
    do_reset();
    rails[0] = 2'b10;
    rails[1] = 2'b01;
    repeat (S + 1) @(negedge clk);
    check("simul_acks", {29'd0, acks}, 3'b011);
    check("simul_bits", {29'd0, ph_bit}, 3'b001);
    rails[0] = 2'b00;
    rails[1] = 2'b00;
    repeat (S + 2) @(negedge clk);
    check("simul_acks_low", {29'd0, acks}, 0);
`ifdef PHASE_RX_ORDER_CHECK_EN
    check("simul_err", {31'd0, err}, 1);
`else
    check("simul_err", {31'd0, err}, 0);
`endif

    // Counter wrap.
    do_reset();
    for (int i = 0; i < 255; i++) begin
      send(0, 2'b10);
      send(1, 2'b01);
      send(2, 2'b10);
    end
    check("wrap_255", {24'd0, cycle_cnt}, 255);
    send(0, 2'b01);
    send(1, 2'b10);
    send(2, 2'b01);
    check("wrap_0", {24'd0, cycle_cnt}, 0);
    check("wrap_err", {31'd0, err}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
